// File: rtl/o_writeback.sv
// o_writeback: collects scaled output vectors from the PE into a small skid
// FIFO and writes them, one row per vector, into the output SRAM.
//
// Ports
//   clk, rst            clock; asynchronous active-low reset
//   start, num_rows_in  begin a tile of num_rows_in rows (sampled in IDLE)
//   vld_in, rdy_out     PE output handshake; vec_in is the vector
//   sram_wready         SRAM can take a write this cycle
//   sram_we/addr/wdata  SRAM write port (addr/wdata hold when we=0)
//   busy, done, err     status: tile active, tile finished pulse, sticky
//                       protocol error (vld_in while no tile is open)
module o_writeback #(
  parameter int EMBED_DIM  = 64,
  parameter int ELEM_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 6
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [ADDR_W:0]             num_rows_in,
  input  logic                        vld_in,
  output logic                        rdy_out,
  input  logic [EMBED_DIM*ELEM_W-1:0] vec_in,
  input  logic                        sram_wready,
  output logic                        sram_we,
  output logic [ADDR_W-1:0]           sram_addr,
  output logic [EMBED_DIM*ELEM_W-1:0] sram_wdata,
  output logic                        busy,
  output logic                        done,
  output logic                        err
);
  localparam int VW    = EMBED_DIM * ELEM_W;
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t state, state_nxt;

  logic [ADDR_W:0] num_rows, acc_cnt, wr_cnt, acc_nxt, wr_nxt;
  logic [VW-1:0]   mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wp, rp;
  logic [PTR_W:0]  cnt, cnt_nxt;
  logic            full, empty, push, pop, start_ok;
  logic [ADDR_W-1:0] addr_q;
  logic [VW-1:0]     wdata_q;

  assign full     = (cnt == (PTR_W+1)'(FIFO_DEPTH));
  assign empty    = (cnt == '0);
  assign push     = vld_in && rdy_out;
  assign pop      = sram_we;
  assign start_ok = (state == S_IDLE) && start;
  assign acc_nxt  = acc_cnt + {{ADDR_W{1'b0}}, push};
  assign wr_nxt   = wr_cnt + {{ADDR_W{1'b0}}, pop};

  always_comb begin
    cnt_nxt = cnt;
    if (push && !pop)      cnt_nxt = cnt + 1'b1;
    else if (!push && pop) cnt_nxt = cnt - 1'b1;
  end

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // ---------------- FSM: next state ----------------
  // Transitions look at the post-edge counter values so that DRAIN is entered
  // on the last accept and DONE follows the last write by exactly one cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = (num_rows_in != '0) ? S_RUN : S_DONE;
      S_RUN:   if (acc_nxt == num_rows) state_nxt = S_DRAIN;
      S_DRAIN: if (cnt_nxt == '0 && wr_nxt == num_rows) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  // rdy_out uses registered state only: a full FIFO blocks even if it pops now.
  always_comb begin
    rdy_out = (state == S_RUN) && !full && (acc_cnt < num_rows);
    sram_we = ((state == S_RUN) || (state == S_DRAIN)) && !empty && sram_wready;
    busy    = (state == S_RUN) || (state == S_DRAIN);
    done    = (state == S_DONE);
  end

  // Address/data follow the FIFO head while writing and hold otherwise.
  assign sram_addr  = sram_we ? wr_cnt[ADDR_W-1:0] : addr_q;
  assign sram_wdata = sram_we ? mem[rp] : wdata_q;

  // ---------------- counters, FIFO control, held outputs ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      num_rows <= '0;
      acc_cnt  <= '0;
      wr_cnt   <= '0;
      wp       <= '0;
      rp       <= '0;
      cnt      <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      err      <= 1'b0;
    end else begin
      if (start_ok) begin
        num_rows <= num_rows_in;
        acc_cnt  <= '0;
        wr_cnt   <= '0;
      end else begin
        acc_cnt  <= acc_nxt;
        wr_cnt   <= wr_nxt;
      end
      if (push) wp <= wp + 1'b1;
      if (pop) begin
        rp      <= rp + 1'b1;
        addr_q  <= wr_cnt[ADDR_W-1:0];
        wdata_q <= mem[rp];
      end
      cnt <= cnt_nxt;
      if (vld_in && ((state == S_IDLE) || (state == S_DONE))) err <= 1'b1;
    end
  end

  // FIFO storage carries no reset; occupancy is what reset clears.
  always_ff @(posedge clk) begin
    if (push) mem[wp] <= vec_in;
  end

endmodule

// File: doc/o_writeback.md
O_WRITEBACK -- requirements
Module: o_writeback

Interface
REQ-001 SHALL have parameter EMBED_DIM, default 64, number of elements per output vector.
REQ-002 SHALL have parameter ELEM_W, default 8, bits per output element.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, output vector skid buffer depth (power of 2, >=2).
REQ-004 SHALL have parameter ADDR_W, default 6, output SRAM row address width.
REQ-005 SHALL have port clk  in  1  system clock; all state changes on the rising edge.
REQ-006 SHALL have port rst  in  1  system reset; one clock, reset asynchronous and active-low.
REQ-007 SHALL have port start  in  1  one-cycle pulse that begins a tile; sampled only in IDLE.
REQ-008 SHALL have port num_rows_in  in  ADDR_W+1  rows expected this tile; latched on accepted start.
REQ-009 SHALL have port vld_in  in  1  upstream PE output valid.
REQ-010 SHALL have port rdy_out  out  1  ready to the PE output (drives the PE's O_sram_rdy).
REQ-011 SHALL have port vec_in  in  EMBED_DIM*ELEM_W  scaled output vector from the PE.
REQ-012 SHALL have port sram_wready  in  1  output SRAM can take a write this cycle.
REQ-013 SHALL have port sram_we  out  1  output SRAM write enable.
REQ-014 SHALL have port sram_addr  out  ADDR_W  output SRAM row address.
REQ-015 SHALL have port sram_wdata  out  EMBED_DIM*ELEM_W  output SRAM write data.
REQ-016 SHALL have port busy  out  1  high in RUN and DRAIN.
REQ-017 SHALL have port done  out  1  one-cycle pulse when a tile is fully written.
REQ-018 SHALL have port err  out  1  sticky flag: vld_in seen while not accepting a tile.

Function
REQ-019 SHALL implement FSM states IDLE, RUN, DRAIN, DONE, held in registers.
REQ-020 IDLE: start=1 -> latch num_rows_in, clear acc_cnt and wr_cnt; go to RUN if num_rows_in!=0, else DONE.
REQ-021 RUN: acc_cnt reaches num_rows (after the accept of the last row) -> DRAIN.
REQ-022 DRAIN: FIFO empty and wr_cnt==num_rows -> DONE.
REQ-023 DONE: done=1 for exactly one cycle, then IDLE unconditionally.
REQ-024 start outside IDLE SHALL be ignored; num_rows is not re-latched.
REQ-025 rdy_out SHALL equal (state==RUN) && FIFO not full && acc_cnt<num_rows, from registered state only; it does not depend on vld_in.
REQ-026 Accept occurs when vld_in && rdy_out: push vec_in into FIFO, acc_cnt+1.
REQ-027 FIFO full SHALL deassert rdy_out even if a pop occurs that cycle; no push-through-full.
REQ-028 sram_we SHALL equal (state in RUN/DRAIN) && FIFO not empty && sram_wready.
REQ-029 When sram_we=1: sram_wdata = FIFO head, sram_addr = wr_cnt[ADDR_W-1:0]; pop the FIFO; wr_cnt+1.
REQ-030 Latency: a vector accepted in cycle t SHALL appear on sram_we/sram_wdata no earlier than cycle t+1; with an empty FIFO and sram_wready=1, exactly t+1.
REQ-031 Simultaneous push and pop SHALL keep the FIFO occupancy unchanged.
REQ-032 Rows SHALL be written in acceptance order, one write per accepted vector, with no gaps in sram_addr.
REQ-033 When sram_we=0, sram_addr and sram_wdata are don't-care, but SHALL hold their last value.
REQ-034 num_rows = 2^ADDR_W SHALL be legal: addresses 0..2^ADDR_W-1, with counters ADDR_W+1 wide and no wrap before completion.
REQ-035 err SHALL set when vld_in=1 in IDLE or DONE, and clear only on reset.

Reset
REQ-036 When rst=0 the block SHALL asynchronously enter IDLE, empty the FIFO, and clear acc_cnt, wr_cnt and num_rows.
REQ-037 During reset and the cycle after: rdy_out=0, sram_we=0, sram_addr=0, sram_wdata=0, busy=0, done=0, err=0.
REQ-038 Reset mid-tile SHALL discard all buffered vectors; no SRAM write is issued after rst asserts.

Verification
REQ-039 start, num_rows=3, vld_in continuous, sram_wready=1 -> writes to addr 0,1,2 with data in input order, each one cycle after accept; done pulses 1 cycle after last write; busy low afterwards.
REQ-040 num_rows=8, sram_wready=0 for 10 cycles -> rdy_out drops after 4 accepts (FIFO full); on wready=1, all 8 rows are written to addr 0..7 in order, with no loss or duplication.
REQ-041 start with num_rows=0 -> next cycle DONE, done=1 one cycle, no sram_we, rdy_out never high.
REQ-042 Random vld_in/sram_wready toggling, num_rows=64 (ADDR_W=6) -> 64 writes, addresses 0..63 exactly once, data matches the scoreboard, with no wrap.
REQ-043 rst pulsed low while FIFO holds 2 vectors mid-tile -> outputs go to reset values immediately, no further sram_we; a new start with 2 rows writes addr 0,1.
REQ-044 vld_in=1 in IDLE -> err=1 and stays 1 through a subsequent full tile; a second start during RUN is ignored (row count unchanged).
